imm_encoder_loader: RTL

Program loader that performs the inverse of the immediate decode step: accepts an instruction template plus a 32-bit immediate, scatters the immediate into the I-type or B-type bit positions, and writes the finished 32-bit word into instruction memory at consecutive word addresses. It sits between the testbench or boot source and the instruction memory write port. Every word it writes must decode back to the same ImmOp in the core's immediate decoder.

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_encoder_loader_if.sv | 13 +
 rtl/imm_encoder_loader_encode.sv | 45 ++++
 rtl/imm_encoder_loader.sv | 75 +++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Types and constants shared by the immediate encoder/loader and the core's immediate decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_B = 3'b010
  } imm_src_t;

  localparam int I_MIN = -2048;
  localparam int I_MAX = 2047;
  localparam int B_MIN = -4096;
  localparam int B_MAX = 4094;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // Decoder-side view of the same field layout; encoder output must round-trip through this.
  function automatic logic [31:0] imm_decode(input logic [31:0] instr, input logic [2:0] src);
    logic [31:0] res;
    res = '0;
    case (src)
      IMM_I:   res = {{20{instr[31]}}, instr[31:20]};
      IMM_B:   res = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_encoder_loader_if.sv
// Request handshake carrying an instruction template and the immediate to scatter into it.
interface imm_encoder_loader_if #(
  parameter int address_width = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               ImmSrc;
  logic [address_width-1:0] imm;
  logic [address_width-1:0] base;

  modport master (output in_valid, ImmSrc, imm, base, input in_ready);
  modport slave  (input in_valid, ImmSrc, imm, base, output in_ready);
endinterface

// File: rtl/imm_encoder_loader_encode.sv
// Combinational immediate scatter: places imm into I- or B-type fields of base and flags legality.
module imm_encode
  import imm_pkg::*;
#(
  parameter int address_width = 32
) (
  input  logic [address_width-1:0]        base,
  input  logic signed [address_width-1:0] imm,
  input  logic [2:0]                      ImmSrc,
  output logic [address_width-1:0]        word,
  output logic                            legal
);

  function automatic logic i_in_range(input logic signed [address_width-1:0] v);
    return (v >= I_MIN) && (v <= I_MAX);
  endfunction

  // B offsets are halfword-aligned; bit 0 has no field in the instruction.
  function automatic logic b_in_range(input logic signed [address_width-1:0] v);
    return (v[0] == 1'b0) && (v >= B_MIN) && (v <= B_MAX);
  endfunction

  always_comb begin
    word  = base;
    legal = 1'b0;
    case (ImmSrc)
      IMM_I: begin
        word[31:20] = imm[11:0];
        legal       = i_in_range(imm);
      end
      IMM_B: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
        legal       = b_in_range(imm);
      end
      default: begin
        word  = base;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder_loader.sv
// Program loader: encodes immediates into instruction templates and writes them to consecutive words.
module imm_encoder_loader
  import imm_pkg::*;
#(
  parameter int                     address_width = 32,
  parameter int                     mem_words     = 256,
  parameter logic [address_width-1:0] start_addr  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  imm_encoder_loader_if.slave              req,
  output logic                             wr_en,
  output logic [address_width-1:0]         wr_addr,
  output logic [address_width-1:0]         wr_data,
  output logic [$clog2(mem_words):0]       count,
  output logic                             err,
  output logic                             full
);

  localparam int              CW   = $clog2(mem_words) + 1;
  localparam logic [CW-1:0]   LAST = CW'(mem_words - 1);

  logic [1:0]               state;
  logic                     xfer_p0;
  logic [address_width-1:0] enc_word_p0;
  logic                     enc_legal_p0;

  assign req.in_ready = (state == ST_RUN) & ~start;
  assign xfer_p0      = req.in_valid & req.in_ready;
  assign full         = (state == ST_FULL);

  imm_encode #(
    .address_width(address_width)
  ) u_encode (
    .base   (req.base),
    .imm    (req.imm),
    .ImmSrc (req.ImmSrc),
    .word   (enc_word_p0),
    .legal  (enc_legal_p0)
  );

  // p0 -> p1: accepted request becomes a registered write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start) begin
      state <= ST_RUN;
      count <= '0;
      err   <= 1'b0;
      wr_en <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (xfer_p0) begin
        if (enc_legal_p0) begin
          wr_en   <= 1'b1;
          wr_addr <= start_addr + (address_width'(count) << 2);
          wr_data <= enc_word_p0;
          count   <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_FULL;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
